// File: rtl/wave_loader_pkg.sv
// Shared definitions for the waveform loader slice.
//   WORDS_PER_BEAT : load-path words packed into one DAC beat
//   WORD_IDX_W     : width of the packer lane index
//   wave_loader_state_t : mode of the loader (load / flush / loopback)
package wave_loader_pkg;

  localparam int unsigned WORDS_PER_BEAT = 8;
  localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_BEAT);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOOP  = 2'd2
  } wave_loader_state_t;

endpackage

// File: rtl/wave_loader_word_packer.sv
// Packs WORD_W-bit load words into a BEAT_W-bit beat, word 0 in the LSBs.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clear           : synchronous empty of the packer
//   word, acc, last : accepted load word, accept strobe, last-of-waveform
//   flush           : request to emit a partial beat (zero padded)
//   take            : the output register consumes the offered beat this cycle
//   beat            : beat offered (includes the word accepted this cycle)
//   beat_want       : a complete, terminated or flushed beat is on offer
//   idx             : next lane to be written
//   pend            : a tlast-terminated beat is waiting for the output register
//   busy            : packer holds data
module wave_loader_word_packer
  import wave_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BEAT_W = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [WORD_W-1:0]     word,
  input  logic                  acc,
  input  logic                  last,
  input  logic                  flush,
  input  logic                  take,
  output logic [BEAT_W-1:0]     beat,
  output logic                  beat_want,
  output logic [WORD_IDX_W-1:0] idx,
  output logic                  pend,
  output logic                  busy
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BEAT - 1);

  logic [BEAT_W-1:0] data;

  // Unfilled lanes stay zero because data is cleared whenever a beat leaves.
  always_comb begin
    beat = data;
    if (acc) beat[idx*WORD_W +: WORD_W] = word;
  end

  // A tlast word accepted while the output register is blocked parks the beat
  // in pend; the loader stops accepting words until it has been taken.
  always_comb begin
    beat_want = pend || (acc && (last || idx == LAST_IDX)) || (flush && idx != '0);
    busy      = pend || (idx != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      idx  <= '0;
      pend <= 1'b0;
    end else if (clear || take) begin
      data <= '0;
      idx  <= '0;
      pend <= 1'b0;
    end else if (acc) begin
      data <= beat;
      if (last) pend <= 1'b1;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/wave_loader.sv
// Selects what is written into the per-channel waveform FIFO: packed PS/DMA
// load words (mux_sel=0) or DAC loopback beats (mux_sel=1).
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   clear                            : sync pulse, empties datapath, zeroes stats
//   mux_sel                          : 0 = load, 1 = loopback
//   s_load_tdata/tvalid/tready/tlast : load word stream
//   loop_tdata, loop_valid           : loopback beats, no backpressure
//   m_axis_tdata/tvalid/tready       : beat stream to the FIFO
//   beat_count                       : saturating handshake count
//   overflow                         : sticky loopback drop flag
//   busy                             : packer or output register holds data
//   checksum                         : running XOR of emitted beats, only with
//                                      WAVE_LOADER_CHECKSUM_EN defined
module wave_loader
  import wave_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BEAT_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mux_sel,
  input  logic [WORD_W-1:0] s_load_tdata,
  input  logic              s_load_tvalid,
  output logic              s_load_tready,
  input  logic              s_load_tlast,
  input  logic [BEAT_W-1:0] loop_tdata,
  input  logic              loop_valid,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  beat_count,
  output logic              overflow,
  output logic              busy
`ifdef WAVE_LOADER_CHECKSUM_EN
  ,
  output logic [BEAT_W-1:0] checksum
`endif
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BEAT - 1);

  wave_loader_state_t    state;
  logic                  out_valid;
  logic [BEAT_W-1:0]     out_data;
  logic                  drain, can_load, illegal;
  logic                  pk_acc, pk_flush, pk_take, pk_clear;
  logic [BEAT_W-1:0]     pk_beat;
  logic                  pk_want, pk_pend, pk_busy;
  logic [WORD_IDX_W-1:0] pk_idx;
  logic                  loop_take, loop_drop;

  always_comb begin
    drain     = out_valid && m_axis_tready;
    can_load  = !out_valid || m_axis_tready;
    illegal   = !(state inside {ST_LOAD, ST_FLUSH, ST_LOOP});
    // Lanes 0..6 can always absorb a word; the final lane needs the output
    // register free. rst gating keeps the output at 0 during reset.
    s_load_tready = rst && !clear && (state == ST_LOAD) && !pk_pend &&
                    (can_load || pk_idx != LAST_IDX);
    pk_acc    = s_load_tvalid && s_load_tready;
    pk_flush  = (state == ST_FLUSH);
    pk_take   = !clear && pk_want && can_load &&
                ((state == ST_LOAD) || (state == ST_FLUSH));
    pk_clear  = clear || illegal;
    loop_take = !clear && (state == ST_LOOP) && loop_valid && can_load;
    loop_drop = !clear && (state == ST_LOOP) && loop_valid && !can_load;
  end

  wave_loader_word_packer #(
    .WORD_W (WORD_W),
    .BEAT_W (BEAT_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .word      (s_load_tdata),
    .acc       (pk_acc),
    .last      (s_load_tlast),
    .flush     (pk_flush),
    .take      (pk_take),
    .beat      (pk_beat),
    .beat_want (pk_want),
    .idx       (pk_idx),
    .pend      (pk_pend),
    .busy      (pk_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LOAD;
      out_valid  <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
      overflow   <= 1'b0;
`ifdef WAVE_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else if (clear) begin
      state      <= mux_sel ? ST_LOOP : ST_LOAD;
      out_valid  <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
      overflow   <= 1'b0;
`ifdef WAVE_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      if (drain) begin
        if (beat_count != '1) beat_count <= beat_count + 1'b1;
`ifdef WAVE_LOADER_CHECKSUM_EN
        checksum <= checksum ^ out_data;
`endif
      end
      if (pk_take) begin
        out_valid <= 1'b1;
        out_data  <= pk_beat;
      end else if (loop_take) begin
        out_valid <= 1'b1;
        out_data  <= loop_tdata;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (loop_drop) overflow <= 1'b1;

      case (state)
        ST_LOAD:  if (mux_sel) state <= ST_FLUSH;
        ST_FLUSH: if (!pk_busy && (!out_valid || drain))
                    state <= mux_sel ? ST_LOOP : ST_LOAD;
        ST_LOOP:  if (!mux_sel && (!out_valid || drain)) state <= ST_LOAD;
        default: begin
          state      <= ST_LOAD;
          out_valid  <= 1'b0;
          out_data   <= '0;
          beat_count <= '0;
          overflow   <= 1'b0;
`ifdef WAVE_LOADER_CHECKSUM_EN
          checksum   <= '0;
`endif
        end
      endcase
    end
  end

  always_comb begin
    m_axis_tvalid = out_valid;
    m_axis_tdata  = out_data;
    busy          = pk_busy || out_valid;
  end

endmodule

// File: tb/tb_wave_loader.sv
module tb_wave_loader;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         mux_sel;
  logic [31:0]  s_load_tdata;
  logic         s_load_tvalid;
  logic         s_load_tready;
  logic         s_load_tlast;
  logic [255:0] loop_tdata;
  logic         loop_valid;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [15:0]  beat_count;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  wave_loader #(
    .WORD_W (32),
    .BEAT_W (256),
    .CNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .mux_sel       (mux_sel),
    .s_load_tdata  (s_load_tdata),
    .s_load_tvalid (s_load_tvalid),
    .s_load_tready (s_load_tready),
    .s_load_tlast  (s_load_tlast),
    .loop_tdata    (loop_tdata),
    .loop_valid    (loop_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .beat_count    (beat_count),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat whose lanes 0..n-1 hold base, base+1, ...; remaining lanes zero.
  function automatic logic [255:0] mk(input logic [31:0] base, input int n);
    logic [255:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[32*k +: 32] = base + 32'(k);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    s_load_tdata  = d;
    s_load_tvalid = 1'b1;
    s_load_tlast  = l;
    #1;
    chk("load_tready", s_load_tready, 1);
    tick();
    s_load_tvalid = 1'b0;
    s_load_tlast  = 1'b0;
  endtask

  task automatic send_loop(input logic [255:0] d);
    loop_tdata = d;
    loop_valid = 1'b1;
    tick();
    loop_valid = 1'b0;
  endtask

  logic [255:0] lbeat [4];
  logic [255:0] bx, by;

  initial begin
    rst = 1'b0; clear = 1'b0; mux_sel = 1'b0;
    s_load_tdata = '0; s_load_tvalid = 1'b0; s_load_tlast = 1'b0;
    loop_tdata = '0; loop_valid = 1'b0; m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) lbeat[k] = {8{32'hC0DE0000 + 32'(k)}};
    bx = {8{32'hAAAA5555}};
    by = {8{32'h1234ABCD}};

    // Reset values
    tick(); tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tready", s_load_tready, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // 16 words 1..16 with the FIFO always ready: two full beats
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send_word(32'(i), 1'b0);
      if (i == 8) begin
        chk("t1_beat0_valid", m_axis_tvalid, 1);
        chk("t1_beat0_data", m_axis_tdata, mk(32'd1, 8));
      end
      if (i == 9) chk("t1_count1", beat_count, 1);
    end
    chk("t1_beat1_valid", m_axis_tvalid, 1);
    chk("t1_beat1_data", m_axis_tdata, mk(32'd9, 8));
    tick();
    chk("t1_count2", beat_count, 2);
    chk("t1_idle_valid", m_axis_tvalid, 0);

    // A, B, C with tlast on C: one zero-padded beat, 1-cycle latency
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b0);
    chk("t2_no_early_valid", m_axis_tvalid, 0);
    send_word(32'hC, 1'b1);
    chk("t2_valid", m_axis_tvalid, 1);
    chk("t2_data", m_axis_tdata, mk(32'hA, 3));
    tick();
    chk("t2_count", beat_count, 3);
    chk("t2_busy", busy, 0);

    // FIFO full: first beat parks in the output register, seven more words
    // fill lanes 0..6, then the final lane is refused
    m_axis_tready = 1'b0;
    for (int i = 0; i < 15; i++) send_word(32'h101 + 32'(i), 1'b0);
    s_load_tdata  = 32'h110;
    s_load_tvalid = 1'b1;
    #1;
    chk("t3_blocked", s_load_tready, 0);
    tick(); tick();
    chk("t3_hold_valid", m_axis_tvalid, 1);
    chk("t3_hold_data", m_axis_tdata, mk(32'h101, 8));
    chk("t3_hold_count", beat_count, 3);
    m_axis_tready = 1'b1;
    #1;
    chk("t3_unblocked", s_load_tready, 1);
    tick();
    s_load_tvalid = 1'b0;
    chk("t3_count", beat_count, 4);
    chk("t3_beat2_data", m_axis_tdata, mk(32'h109, 8));
    tick();
    chk("t3_count_final", beat_count, 5);

    // clear, then 5 words and a switch to loopback
    clear = 1'b1;
    #1;
    chk("clr_tready", s_load_tready, 0);
    tick();
    clear = 1'b0;
    chk("clr_count", beat_count, 0);
    for (int i = 0; i < 5; i++) send_word(32'h51 + 32'(i), 1'b0);
    mux_sel = 1'b1;
    tick();
    chk("t4_flush_tready", s_load_tready, 0);
    chk("t4_flush_busy", busy, 1);
    chk("t4_pre_valid", m_axis_tvalid, 0);
    tick();
    chk("t4_flush_valid", m_axis_tvalid, 1);
    chk("t4_flush_data", m_axis_tdata, mk(32'h51, 5));
    tick();
    chk("t4_flush_count", beat_count, 1);
    for (int k = 0; k < 4; k++) begin
      send_loop(lbeat[k]);
      chk("t4_loop_valid", m_axis_tvalid, 1);
      chk("t4_loop_data", m_axis_tdata, lbeat[k]);
    end
    tick();
    chk("t4_count", beat_count, 5);
    chk("t4_loop_tready", s_load_tready, 0);

    // Loopback with the FIFO full: second beat is dropped
    m_axis_tready = 1'b0;
    send_loop(bx);
    chk("t5_held_valid", m_axis_tvalid, 1);
    chk("t5_no_ovf", overflow, 0);
    send_loop(by);
    chk("t5_ovf", overflow, 1);
    chk("t5_held_data", m_axis_tdata, bx);
    tick();
    chk("t5_ovf_sticky", overflow, 1);
    m_axis_tready = 1'b1;
    tick();
    chk("t5_count", beat_count, 6);
    chk("t5_ovf_after_drain", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_ovf_cleared", overflow, 0);
    chk("t5_count_cleared", beat_count, 0);

    // Back to load, reset mid-beat, then a clean beat from lane 0
    mux_sel = 1'b0;
    tick();
    #1;
    chk("t6_load_tready", s_load_tready, 1);
    for (int i = 0; i < 4; i++) send_word(32'h61 + 32'(i), 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_tready", s_load_tready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", beat_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) send_word(32'h71 + 32'(i), 1'b0);
    chk("t6_valid", m_axis_tvalid, 1);
    chk("t6_data", m_axis_tdata, mk(32'h71, 8));
    tick();
    chk("t6_count", beat_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
